// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, iteration counter width and the
// sequential multiplier's state encoding.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;
endpackage

// File: rtl/mult_seq_cu.sv
// Control unit of the shift-add multiplier: state machine, iteration counter,
// start detection and the We/Busy handshake.
module mult_seq_cu
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CW    = CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_start,
  output logic o_run,
  output logic o_last,
  output logic o_we,
  output logic o_busy
);

  mult_state_t     r_state;
  mult_state_t     w_state_next;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (o_start)
        r_cnt <= '0;
      else if (o_run)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_start      = 1'b0;
    o_run        = 1'b0;
    o_last       = 1'b0;
    o_we         = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          o_start      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        o_run  = 1'b1;
        o_busy = 1'b1;
        // Final iteration: the product register is complete on this edge.
        if (r_cnt == CW'(WIDTH - 1)) begin
          o_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        o_we         = 1'b1;
        o_busy       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/mult_seq_dp.sv
// Combinational step of the shift-add multiplier: conditional add of the
// multiplicand into the upper half, then a one-bit right shift of the product.
module mult_seq_dp
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0]   i_p_hi,
  input  logic [WIDTH-1:0]   i_p_lo,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_p_next
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    // The extra sum bit keeps the carry, so the shift never loses it.
    w_sum    = {1'b0, i_p_hi} + (i_p_lo[0] ? {1'b0, i_m} : '0);
    o_p_next = {w_sum, i_p_lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle 32x32 shift-add multiplier producing HI/LO for MULT/MULTU.
// Define MULT_SEQ_SIGNED_EN to add the Is_Signed port and signed products.
module mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic             Is_Signed,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Mult_Result_Hi,
  output logic [WIDTH-1:0] Mult_Result_Lo,
  output logic             We,
  output logic             Busy
);

  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_p;
  logic               w_start;
  logic               w_run;
  logic               w_last;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_p_final;
  logic [WIDTH-1:0]   w_a_op;
  logic [WIDTH-1:0]   w_b_op;

  mult_seq_cu #(.WIDTH(WIDTH), .CW($clog2(WIDTH))) u_cu (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_en    (En),
    .o_start (w_start),
    .o_run   (w_run),
    .o_last  (w_last),
    .o_we    (We),
    .o_busy  (Busy)
  );

  mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .i_p_hi   (r_p[2*WIDTH-1:WIDTH]),
    .i_p_lo   (r_p[WIDTH-1:0]),
    .i_m      (r_m),
    .o_p_next (w_p_next)
  );

`ifdef MULT_SEQ_SIGNED_EN
  logic r_neg;
  logic w_neg_start;

  // Signed operands run through the unsigned core as magnitudes; the most
  // negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    w_a_op      = (Is_Signed && A[WIDTH-1]) ? -A : A;
    w_b_op      = (Is_Signed && B[WIDTH-1]) ? -B : B;
    w_neg_start = Is_Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
    w_p_final   = r_neg ? -w_p_next : w_p_next;
  end
`else
  always_comb begin
    w_a_op    = A;
    w_b_op    = B;
    w_p_final = w_p_next;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_m   <= '0;
      r_p   <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      r_neg <= 1'b0;
`endif
    end else if (w_start) begin
      r_m   <= w_a_op;
      r_p   <= {{WIDTH{1'b0}}, w_b_op};
`ifdef MULT_SEQ_SIGNED_EN
      r_neg <= w_neg_start;
`endif
    end else if (w_run) begin
      r_p <= w_last ? w_p_final : w_p_next;
    end
  end

  assign Mult_Result_Hi = r_p[2*WIDTH-1:WIDTH];
  assign Mult_Result_Lo = r_p[WIDTH-1:0];

endmodule
